// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------------------
// loader_pkg
// Shared types and constants for the APB-to-BRAM loader.
//   state_t  : loader FSM states (RD_WAIT only exists when readback is built)
//   bank_t   : BRAM bank selector values held in the BANK register
//   OFF_*    : APB register offsets decoded from PADDR
// Configuration macro: LOADER_READBACK_EN (enables the RD_WAIT state and the
// RLO/RHI readback path).
// ---------------------------------------------------------------------------
package loader_pkg;

`ifdef LOADER_READBACK_EN
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        ACK     = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACK     = 2'd2
    } state_t;
`endif

    typedef enum logic [1:0] {
        BANK_A    = 2'd0,
        BANK_B    = 2'd1,
        BANK_C    = 2'd2,
        BANK_NONE = 2'd3
    } bank_t;

    localparam logic [3:0] OFF_BANK   = 4'd0;
    localparam logic [3:0] OFF_PTR    = 4'd1;
    localparam logic [3:0] OFF_WLO    = 4'd2;
    localparam logic [3:0] OFF_WHI    = 4'd3;
    localparam logic [3:0] OFF_RLO    = 4'd4;
    localparam logic [3:0] OFF_RHI    = 4'd5;
    localparam logic [3:0] OFF_STATUS = 4'd6;

endpackage

// File: rtl/apb_bram_loader.sv
// ---------------------------------------------------------------------------
// apb_bram_loader
// APB slave that loads (and optionally reads back) 32-bit words in one of
// three BRAM banks through their shared port 1. Software selects a bank,
// sets a word pointer, stages the low half in WLO and commits the word by
// writing WHI, which also advances the pointer.
//
// Ports:
//   clk, resetn                      clock, async active-low reset
//   PSEL/PENABLE/PWRITE/PADDR/PWDATA APB slave request
//   PRDATA, PREADY                   APB slave response (registered)
//   bram_addr_ext, bram_wdata_ext    shared BRAM port-1 address / data
//   bram_we_{a,b,c}_ext              per-bank byte write enables
//   bram_rdata_{a,b,c}_ext           per-bank read data (1-cycle latency)
//
// Configuration macro: LOADER_READBACK_EN
//   defined   : RLO read waits one cycle and snapshots the selected bank's
//               word; RLO/RHI return its halves, RHI advances the pointer.
//   undefined : RLO/RHI read as 0 with no wait and no pointer change.
// ---------------------------------------------------------------------------
module apb_bram_loader #(
    parameter int AWIDTH     = 10,
    parameter int DWIDTH     = 8,
    parameter int MASK_WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         PSEL,
    input  logic                         PENABLE,
    input  logic                         PWRITE,
    input  logic [3:0]                   PADDR,
    input  logic [15:0]                  PWDATA,
    output logic [15:0]                  PRDATA,
    output logic                         PREADY,
    output logic [AWIDTH-1:0]            bram_addr_ext,
    output logic [MASK_WIDTH*DWIDTH-1:0] bram_wdata_ext,
    output logic [MASK_WIDTH-1:0]        bram_we_a_ext,
    output logic [MASK_WIDTH-1:0]        bram_we_b_ext,
    output logic [MASK_WIDTH-1:0]        bram_we_c_ext,
    input  logic [MASK_WIDTH*DWIDTH-1:0] bram_rdata_a_ext,
    input  logic [MASK_WIDTH*DWIDTH-1:0] bram_rdata_b_ext,
    input  logic [MASK_WIDTH*DWIDTH-1:0] bram_rdata_c_ext
);
    import loader_pkg::*;

    localparam int BW = MASK_WIDTH * DWIDTH;

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_addr;
    logic              r_wr;
    bank_t             r_bank;
    logic [AWIDTH-1:0] r_ptr;
    logic [15:0]       r_wlo;
    logic [15:0]       r_whi;
    logic [15:0]       r_prdata;
    logic              r_err;

    logic              w_access;
    logic              w_rlo_wait;
    logic              w_whi_ack;
    logic              w_ptr_inc;
    logic [15:0]       w_rd_mux;

`ifdef LOADER_READBACK_EN
    logic [BW-1:0]     r_shadow;
    logic [BW-1:0]     w_bank_rdata;
`else
    logic              w_unused_rdata;
`endif

    assign w_access = PSEL & PENABLE;

    // The transaction is latched on acceptance, so ACK-cycle behaviour
    // (write enables, pointer increment) does not depend on the bus.
    assign w_whi_ack = (r_state == ACK) && r_wr && (r_addr == OFF_WHI);

`ifdef LOADER_READBACK_EN
    assign w_rlo_wait = ~PWRITE && (PADDR == OFF_RLO);
    assign w_ptr_inc  = (r_wr && (r_addr == OFF_WHI)) ||
                        (~r_wr && (r_addr == OFF_RHI));
`else
    assign w_rlo_wait     = 1'b0;
    assign w_ptr_inc      = r_wr && (r_addr == OFF_WHI);
    assign w_unused_rdata = ^{bram_rdata_a_ext, bram_rdata_b_ext, bram_rdata_c_ext};
`endif

    assign PREADY         = (r_state == ACK);
    assign PRDATA         = r_prdata;
    assign bram_addr_ext  = r_ptr;
    assign bram_wdata_ext = BW'({r_whi, r_wlo});
    assign bram_we_a_ext  = {MASK_WIDTH{w_whi_ack && (r_bank == BANK_A)}};
    assign bram_we_b_ext  = {MASK_WIDTH{w_whi_ack && (r_bank == BANK_B)}};
    assign bram_we_c_ext  = {MASK_WIDTH{w_whi_ack && (r_bank == BANK_C)}};

`ifdef LOADER_READBACK_EN
    // Bank 3 selects nothing; a snapshot from it reads as zero.
    always_comb begin
        w_bank_rdata = '0;
        case (r_bank)
            BANK_A:  w_bank_rdata = bram_rdata_a_ext;
            BANK_B:  w_bank_rdata = bram_rdata_b_ext;
            BANK_C:  w_bank_rdata = bram_rdata_c_ext;
            default: w_bank_rdata = '0;
        endcase
    end
`endif

    // Register read decode for every read answered straight from IDLE.
    always_comb begin
        w_rd_mux = 16'h0000;
        case (PADDR)
            OFF_BANK:   w_rd_mux = {14'd0, r_bank};
            OFF_PTR:    w_rd_mux = 16'(r_ptr);
            OFF_WLO:    w_rd_mux = r_wlo;
            OFF_WHI:    w_rd_mux = r_whi;
            OFF_STATUS: w_rd_mux = {r_err, 3'b000, r_bank, 10'(r_ptr)};
`ifdef LOADER_READBACK_EN
            OFF_RHI:    w_rd_mux = r_shadow[BW-1 -: 16];
`endif
            default:    w_rd_mux = 16'h0000;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_access) begin
`ifdef LOADER_READBACK_EN
                    w_next = w_rlo_wait ? RD_WAIT : ACK;
`else
                    w_next = ACK;
`endif
                end
            end
`ifdef LOADER_READBACK_EN
            RD_WAIT: w_next = ACK;
`endif
            ACK:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Register writes take effect on acceptance so WHI data is already on
    // bram_wdata_ext during the ACK cycle that pulses the write enable.
    // Pointer advance and the error flag are applied when leaving ACK.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_addr   <= 4'd0;
            r_wr     <= 1'b0;
            r_bank   <= BANK_A;
            r_ptr    <= '0;
            r_wlo    <= 16'h0000;
            r_whi    <= 16'h0000;
            r_prdata <= 16'h0000;
            r_err    <= 1'b0;
`ifdef LOADER_READBACK_EN
            r_shadow <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_access) begin
                        r_addr <= PADDR;
                        r_wr   <= PWRITE;
                        if (PWRITE) begin
                            case (PADDR)
                                OFF_BANK: begin
                                    r_bank <= bank_t'(PWDATA[1:0]);
                                    r_err  <= 1'b0;
                                end
                                OFF_PTR: r_ptr <= PWDATA[AWIDTH-1:0];
                                OFF_WLO: r_wlo <= PWDATA;
                                OFF_WHI: r_whi <= PWDATA;
                                default: ;
                            endcase
                        end else if (!w_rlo_wait) begin
                            r_prdata <= w_rd_mux;
                        end
                    end
                end
`ifdef LOADER_READBACK_EN
                RD_WAIT: begin
                    r_shadow <= w_bank_rdata;
                    r_prdata <= w_bank_rdata[15:0];
                end
`endif
                ACK: begin
                    if (w_ptr_inc) begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                    if (w_whi_ack && (r_bank == BANK_NONE)) begin
                        r_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/apb_bram_loader.md
APB_BRAM_LOADER -- requirements
Module: apb_bram_loader

Interface
REQ-001 Parameters SHALL be: AWIDTH, 10, BRAM word address width; DWIDTH, 8, byte width; MASK_WIDTH, 4, bytes per BRAM word.
REQ-002 Ports SHALL be: clk  in  1  single clock, all logic on posedge.
REQ-003 resetn  in  1  reset, asynchronous assert, active-low.
REQ-004 PSEL, PENABLE, PWRITE  in  1 each  APB slave controls.
REQ-005 PADDR  in  4  register offset; PWDATA  in  16  write data.
REQ-006 PRDATA  out  16  read data; PREADY  out  1  transfer-complete.
REQ-007 bram_addr_ext  out  AWIDTH  shared port-1 address to BRAMs A/B/C.
REQ-008 bram_wdata_ext  out  MASK_WIDTH*DWIDTH  shared port-1 write data.
REQ-009 bram_we_a_ext, bram_we_b_ext, bram_we_c_ext  out  MASK_WIDTH each  per-bank byte write enables.
REQ-010 bram_rdata_a_ext, bram_rdata_b_ext, bram_rdata_c_ext  in  MASK_WIDTH*DWIDTH each  port-1 read data, 1-cycle registered latency.

Function
REQ-011 Registers SHALL be: 0 BANK (bits[1:0]: 0=A,1=B,2=C,3=none), 1 PTR (bits[AWIDTH-1:0]), 2 WLO, 3 WHI, 4 RLO, 5 RHI, 6 STATUS.
REQ-012 FSM SHALL have states IDLE, RD_WAIT, ACK; PREADY SHALL be 1 only in ACK, for exactly one cycle.
REQ-013 IDLE: on PSEL&PENABLE, write or non-RLO read -> ACK next cycle; RLO read -> RD_WAIT.
REQ-014 RD_WAIT SHALL last one cycle, capture selected bank rdata into 32-bit shadow, then go to ACK.
REQ-015 ACK SHALL return to IDLE unconditionally; a new access needs a fresh setup phase.
REQ-016 bram_addr_ext SHALL equal PTR at all times; bram_wdata_ext SHALL equal {WHI data, WLO staging}.
REQ-017 Write WLO SHALL stage PWDATA only; no BRAM write.
REQ-018 Write WHI SHALL assert the selected bank's we = all-ones exactly in the ACK cycle; other banks' we stay 0.
REQ-019 PTR SHALL increment on leaving ACK after a WHI write or RHI read; AWIDTH-bit wrap (1023 -> 0).
REQ-020 BANK=3 on WHI SHALL assert no we, still increment PTR, and set sticky STATUS[15] (err).
REQ-021 Write BANK SHALL clear err; write PTR SHALL load pointer, no increment.
REQ-022 Read RLO SHALL return shadow[15:0]; RHI SHALL return shadow[31:16]; RHI without prior RLO returns stale shadow.
REQ-023 Read STATUS SHALL return {err, 3'b0, bank[1:0], ptr[9:0]}; reads of BANK/PTR return their values.
REQ-024 Offsets 7-15: writes ignored, reads return 0, PREADY still given.
REQ-025 PRDATA SHALL be registered, valid in ACK, held until next read ACK.

Reset
REQ-026 On resetn low: state IDLE, PREADY 0, PRDATA 0, all we 0, PTR 0, BANK 0, WLO/WHI staging 0, shadow 0, err 0.
REQ-027 Reset mid-transaction SHALL abort with no BRAM write and no PTR change after release.

Configuration
REQ-028 Macro LOADER_READBACK_EN: defined -> RLO/RHI behave per REQ-014/022.
REQ-029 Undefined -> no RD_WAIT state, no shadow; RLO/RHI reads return 0 in one ACK, RHI does not increment PTR.

Structure
REQ-030 Package loader_pkg SHALL hold state enum, bank enum, register offset constants.
REQ-031 Single flat module; no sub-module.

Verification
REQ-032 BANK=1, PTR=5, WLO=0x5678, WHI=0x1234 -> bram_we_b_ext=4'hF one cycle at addr 5, data 0x12345678, PTR=6.
REQ-033 After REQ-032, PTR=5, read RLO then RHI -> PRDATA 0x5678 then 0x1234, RLO PREADY two cycles after access, PTR=6.
REQ-034 PTR=1023, WLO/WHI write -> PTR reads 0.
REQ-035 BANK=3, WHI write -> no we asserted, STATUS[15]=1; BANK write -> STATUS[15]=0.
REQ-036 Read offset 0xA -> PRDATA 0; write offset 0xA -> no state change.
REQ-037 resetn low during RD_WAIT -> PREADY 0, we 0, PTR 0 after release; readback-off build RLO returns 0 with PREADY one cycle after access.
